// File: rtl/hex_entry_pkg.sv
// Shared constants and types for the hex_entry push-button editor.
package hex_entry_pkg;

    localparam int unsigned NUM_PB    = 4;
    localparam int unsigned PB_INC    = 0;
    localparam int unsigned PB_DEC    = 1;
    localparam int unsigned PB_LEFT   = 2;
    localparam int unsigned PB_COMMIT = 3;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_INC,
        ACT_DEC,
        ACT_LEFT,
        ACT_COMMIT
    } act_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // Only the highest-priority event in a cycle acts.
    function automatic act_t pick_action(input logic commit_ev, input logic left_ev,
                                         input logic inc_ev, input logic dec_ev);
        if (commit_ev) return ACT_COMMIT;
        if (left_ev)   return ACT_LEFT;
        if (inc_ev)    return ACT_INC;
        if (dec_ev)    return ACT_DEC;
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/hex_entry_pb_debounce.sv
// Single-button debouncer: accepted (stable) level plus a one-cycle press pulse
// registered on the same edge that the stable level falls.
module pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (raw_i == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = raw_i;
            cnt_d    = '0;
            press_d  = ~raw_i;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/hex_entry.sv
// Push-button hex value editor: INC/DEC/LEFT/COMMIT edit a NUM_DIGITS-nibble value.
// Define HEX_ENTRY_AUTOREPEAT_EN to add hold-to-repeat on INC/DEC.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
`ifdef HEX_ENTRY_AUTOREPEAT_EN
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
`endif
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [3:0]                    PB_sync,
    output logic [4*NUM_DIGITS-1:0]       value,
    output logic [4*NUM_DIGITS-1:0]       committed,
    output logic                          commit_pulse,
    output logic [$clog2(NUM_DIGITS)-1:0] cursor,
    output logic [NUM_DIGITS-1:0]         en_mask,
    output logic                          dirty
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CUR_W = $clog2(NUM_DIGITS);
    localparam int unsigned BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [NUM_PB-1:0] pb_stable;
    logic [NUM_PB-1:0] pb_press;
    logic              inc_ev_c, dec_ev_c;
    logic              unused_stable;

    for (genvar g = 0; g < NUM_PB; g++) begin : g_pb
        pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (CLK),
            .rst_i   (RST),
            .raw_i   (PB_sync[g]),
            .stable_o(pb_stable[g]),
            .press_o (pb_press[g])
        );
    end

    // LEFT/COMMIT levels are never needed, only their press pulses.
    assign unused_stable = ^pb_stable;

`ifdef HEX_ENTRY_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [1:0] rep_ev_c;
    logic       cancel_c;

    assign cancel_c = pb_press[PB_LEFT] | pb_press[PB_COMMIT];

    // One repeat FSM each for INC (0) and DEC (1); extra events are registered pulses.
    for (genvar r = 0; r < 2; r++) begin : g_rpt
        rpt_state_t       state_q;
        logic [RPT_W-1:0] cnt_q;
        logic             ev_q;

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                state_q <= RPT_IDLE;
                cnt_q   <= '0;
                ev_q    <= 1'b0;
            end else begin
                ev_q <= 1'b0;
                case (state_q)
                    RPT_IDLE: begin
                        if (!cancel_c && pb_press[r]) begin
                            state_q <= RPT_DELAY;
                            cnt_q   <= '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (cancel_c || pb_stable[r]) begin
                            state_q <= RPT_IDLE;
                        end else if (cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                            state_q <= RPT_REPEAT;
                            cnt_q   <= '0;
                            ev_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + RPT_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (cancel_c || pb_stable[r]) begin
                            state_q <= RPT_IDLE;
                        end else if (cnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
                            cnt_q <= '0;
                            ev_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + RPT_W'(1);
                        end
                    end
                    default: state_q <= RPT_IDLE;
                endcase
            end
        end

        assign rep_ev_c[r] = ev_q;
    end

    assign inc_ev_c = pb_press[PB_INC] | rep_ev_c[0];
    assign dec_ev_c = pb_press[PB_DEC] | rep_ev_c[1];
`else
    assign inc_ev_c = pb_press[PB_INC];
    assign dec_ev_c = pb_press[PB_DEC];
`endif

    logic [VAL_W-1:0]      value_q, value_d;
    logic [VAL_W-1:0]      committed_q, committed_d;
    logic                  commit_pulse_q, commit_pulse_d;
    logic [CUR_W-1:0]      cursor_q, cursor_d;
    logic [NUM_DIGITS-1:0] en_mask_q, en_mask_d;
    logic                  dirty_q, dirty_d;
    logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [3:0]            nib_c;
    act_t                  act_c;

    always_comb begin
        value_d        = value_q;
        committed_d    = committed_q;
        commit_pulse_d = 1'b0;
        cursor_d       = cursor_q;
        blink_cnt_d    = blink_cnt_q;
        phase_d        = phase_q;
        act_c          = pick_action(pb_press[PB_COMMIT], pb_press[PB_LEFT], inc_ev_c, dec_ev_c);
        nib_c          = value_q[{cursor_q, 2'b00} +: 4];

        case (act_c)
            ACT_INC: value_d[{cursor_q, 2'b00} +: 4] = nib_c + 4'd1;
            ACT_DEC: value_d[{cursor_q, 2'b00} +: 4] = nib_c - 4'd1;
            ACT_LEFT: begin
                if (cursor_q == CUR_W'(NUM_DIGITS - 1)) cursor_d = '0;
                else                                   cursor_d = cursor_q + CUR_W'(1);
            end
            ACT_COMMIT: begin
                committed_d    = value_q;
                commit_pulse_d = 1'b1;
            end
            default: ;
        endcase

        dirty_d = (value_d != committed_d);

        if (blink_cnt_q == BLK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
        end

        // Mask is built from next-state values so it stays aligned with cursor.
        en_mask_d           = '1;
        en_mask_d[cursor_d] = ~phase_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            value_q        <= '0;
            committed_q    <= '0;
            commit_pulse_q <= 1'b0;
            cursor_q       <= '0;
            en_mask_q      <= '1;
            dirty_q        <= 1'b0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
        end else begin
            value_q        <= value_d;
            committed_q    <= committed_d;
            commit_pulse_q <= commit_pulse_d;
            cursor_q       <= cursor_d;
            en_mask_q      <= en_mask_d;
            dirty_q        <= dirty_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
        end
    end

    assign value        = value_q;
    assign committed    = committed_q;
    assign commit_pulse = commit_pulse_q;
    assign cursor       = cursor_q;
    assign en_mask      = en_mask_q;
    assign dirty        = dirty_q;

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: directed scenarios plus random button traffic,
// every cycle compared against a nibble-array reference model.
module tb_hex_entry;

    localparam int ND  = 6;
    localparam int DEB = 4;
    localparam int BLK = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic [3:0]    PB_sync;
    logic [23:0]   value;
    logic [23:0]   committed;
    logic          commit_pulse;
    logic [2:0]    cursor;
    logic [ND-1:0] en_mask;
    logic          dirty;

    always #5 CLK = ~CLK;

    hex_entry #(
        .NUM_DIGITS     (ND),
        .DEBOUNCE_CYCLES(DEB),
`ifdef HEX_ENTRY_AUTOREPEAT_EN
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
`endif
        .BLINK_CYCLES   (BLK)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PB_sync     (PB_sync),
        .value       (value),
        .committed   (committed),
        .commit_pulse(commit_pulse),
        .cursor      (cursor),
        .en_mask     (en_mask),
        .dirty       (dirty)
    );

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: digits as integers, buttons as run-length counters.
    int m_nib[ND];
    int m_com[ND];
    int m_cursor;
    bit m_pulse;
    bit m_stable[4];
    int m_run[4];
    bit m_press[4];
    int m_age[2];
    bit m_rep[2];
    int m_cycles;

    function automatic logic [23:0] pack_nibs(input int n[ND]);
        logic [23:0] v = '0;
        for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'(n[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) begin
            m_nib[i] = 0;
            m_com[i] = 0;
        end
        for (int b = 0; b < 4; b++) begin
            m_stable[b] = 1'b1;
            m_run[b]    = 0;
            m_press[b]  = 1'b0;
        end
        for (int b = 0; b < 2; b++) begin
            m_age[b] = -1;
            m_rep[b] = 1'b0;
        end
        m_cursor = 0;
        m_pulse  = 1'b0;
        m_cycles = 0;
    endtask

    task automatic model_edge(input logic [3:0] raw);
        bit inc_e, dec_e;
        inc_e   = m_press[0] || m_rep[0];
        dec_e   = m_press[1] || m_rep[1];
        m_pulse = 1'b0;
        if (m_press[3]) begin
            m_com   = m_nib;
            m_pulse = 1'b1;
        end else if (m_press[2]) begin
            m_cursor = (m_cursor + 1) % ND;
        end else if (inc_e) begin
            m_nib[m_cursor] = (m_nib[m_cursor] + 1) % 16;
        end else if (dec_e) begin
            m_nib[m_cursor] = (m_nib[m_cursor] + 15) % 16;
        end
`ifdef HEX_ENTRY_AUTOREPEAT_EN
        for (int b = 0; b < 2; b++) begin
            m_rep[b] = 1'b0;
            if (m_press[2] || m_press[3]) m_age[b] = -1;
            else if (m_age[b] >= 0 && m_stable[b]) m_age[b] = -1;
            else if (m_press[b]) m_age[b] = 0;
            else if (m_age[b] >= 0) begin
                m_age[b]++;
                if (m_age[b] == RD || (m_age[b] > RD && (m_age[b] - RD) % RP == 0))
                    m_rep[b] = 1'b1;
            end
        end
`endif
        for (int b = 0; b < 4; b++) begin
            m_press[b] = 1'b0;
            if (raw[b] != m_stable[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_stable[b] = raw[b];
                    m_run[b]    = 0;
                    m_press[b]  = !raw[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_cycles++;
    endtask

    task automatic check_outputs();
        logic [ND-1:0] em;
        em           = '1;
        em[m_cursor] = ((m_cycles / BLK) % 2) == 0;
        check("value",        32'(value),        32'(pack_nibs(m_nib)));
        check("committed",    32'(committed),    32'(pack_nibs(m_com)));
        check("commit_pulse", 32'(commit_pulse), 32'(m_pulse));
        check("cursor",       32'(cursor),       32'(m_cursor));
        check("dirty",        32'(dirty),        32'(pack_nibs(m_nib) != pack_nibs(m_com)));
        check("en_mask",      32'(en_mask),      32'(em));
        if (commit_pulse === 1'b1) pulses++;
    endtask

    task automatic step(input logic [3:0] raw);
        PB_sync = raw;
        @(posedge CLK);
        model_edge(raw);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic hold(input logic [3:0] raw, input int n);
        repeat (n) step(raw);
    endtask

    task automatic press(input int b);
        hold(4'hF ^ (4'(1) << b), DEB + 1);
        hold(4'hF, DEB + 1);
    endtask

    // Asynchronous reset applied mid-cycle; outputs checked before any clock edge.
    task automatic do_reset();
        RST = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rnd;
        PB_sync = 4'hF;
        RST     = 1'b1;
        model_reset();
        @(negedge CLK);
        check_outputs();
        RST = 1'b0;

        // INC held 10 cycles: exactly one increment, one cycle after stable low
        hold(4'b1110, DEB);
        check("t1_before", 32'(value), 32'h0);
        step(4'b1110);
        check("t1_after", 32'(value), 32'h1);
        hold(4'b1110, 5);
        hold(4'hF, DEB + 2);
        check("t1_value", 32'(value), 32'h1);
        check("t1_dirty", 32'(dirty), 32'h1);

        // Glitch shorter than the debounce window
        hold(4'b1110, DEB - 1);
        hold(4'hF, DEB + 2);
        check("t2_glitch", 32'(value), 32'h1);

        // Cursor to digit 5, DEC wraps to F, sixth LEFT wraps cursor
        do_reset();
        repeat (5) press(2);
        press(1);
        check("t3_value", 32'(value), 32'hF00000);
        check("t3_cursor", 32'(cursor), 32'd5);
        press(2);
        check("t3_wrap", 32'(cursor), 32'd0);

        // F -> 0 without carry
        do_reset();
        press(1);
        check("t4_f", 32'(value), 32'h00000F);
        press(0);
        check("t4_nocarry", 32'(value), 32'h000000);

        // INC and COMMIT together: commit wins
        press(0);
        pulses = 0;
        hold(4'b0110, DEB + 1);
        hold(4'hF, DEB + 1);
        check("t5_pulses", 32'(pulses), 32'd1);
        check("t5_committed", 32'(committed), 32'h1);
        check("t5_value", 32'(value), 32'h1);
        check("t5_dirty", 32'(dirty), 32'h0);

        // Build 0x123456, then reset mid-debounce with INC held
        do_reset();
        for (int d = 0; d < ND; d++) begin
            repeat (6 - d) press(0);
            press(2);
        end
        check("t6_built", 32'(value), 32'h123456);
        hold(4'b1110, 2);
        do_reset();
        check("t6_rst_value", 32'(value), 32'h0);
        check("t6_rst_mask", 32'(en_mask), 32'h3F);
        hold(4'b1110, DEB);
        check("t6_no_early", 32'(value), 32'h0);
        step(4'b1110);
        check("t6_full_window", 32'(value), 32'h1);
        hold(4'hF, DEB + 2);

        // Long hold: auto-repeat only when the feature is built in
        do_reset();
        hold(4'b1110, 40);
        hold(4'hF, DEB + 2);
`ifdef HEX_ENTRY_AUTOREPEAT_EN
        check("t7_hold40", 32'(value), 32'h5);
`else
        check("t7_hold40", 32'(value), 32'h1);
`endif

        // Random button traffic, including glitches and simultaneous presses
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) < 2) rnd = 4'hF;
            else                          rnd = 4'($urandom) | 4'($urandom);
            hold(rnd, $urandom_range(1, 8));
        end
        hold(4'hF, DEB + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
